// File: rtl/psum_deskew_accum_if.sv
// Bus bundle for the psum deskew/accumulate block: array-side input, FIFO-side output, status.
interface psum_deskew_accum_if #(
    parameter int unsigned NUM_COLS  = 16,
    parameter int unsigned ACC_DEPTH = 32
);
    localparam int unsigned LW = NUM_COLS * 32;
    localparam int unsigned AW = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;

    logic          in_valid;
    logic [LW-1:0] in_sum;
    logic [AW-1:0] in_addr;
    logic          acc_first;
    logic          acc_last;
    logic          out_valid;
    logic          out_ready;
    logic [LW-1:0] out_data;
    logic          stall;
    logic          err_ovf;
    logic          err_sat;
    logic          err_clr;

    // Producer/consumer side (array controller, output sink)
    modport master (
        output in_valid, in_sum, in_addr, acc_first, acc_last, out_ready, err_clr,
        input  out_valid, out_data, stall, err_ovf, err_sat
    );

    // Block side
    modport slave (
        input  in_valid, in_sum, in_addr, acc_first, acc_last, out_ready, err_clr,
        output out_valid, out_data, stall, err_ovf, err_sat
    );
endinterface

// File: rtl/psum_deskew_accum.sv
// Deskews skewed PE-array bottom-row psums, accumulates them into a bank with
// 32-bit saturation, and queues finished vectors in a small output FIFO.
module psum_deskew_accum #(
    parameter int unsigned NUM_COLS   = 16,
    parameter int unsigned ACC_DEPTH  = 32,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    psum_deskew_accum_if.slave bus
);
    localparam int unsigned LW = NUM_COLS * 32;
    localparam int unsigned AW = (ACC_DEPTH > 1) ? $clog2(ACC_DEPTH) : 1;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam int unsigned TW = $clog2(FIFO_DEPTH + NUM_COLS + 1);

    logic [NUM_COLS-1:0] v_pipe;
    logic [NUM_COLS-1:0] f_pipe;
    logic [NUM_COLS-1:0] l_pipe;
    logic [AW-1:0]       a_pipe [NUM_COLS];

    logic                al_valid;
    logic                al_first;
    logic                al_last;
    logic [AW-1:0]       al_addr;
    logic [LW-1:0]       al_sum;
    logic [LW-1:0]       acc_old;
    logic [LW-1:0]       new_vec;
    logic [NUM_COLS-1:0] lane_clip;

    logic [LW-1:0]       bank [ACC_DEPTH];
    logic [LW-1:0]       fifo_mem [FIFO_DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic [CW-1:0]       count;
    logic [CW-1:0]       count_nxt;
    logic [TW-1:0]       pending;
    logic                out_valid_q;
    logic                ovf_q;
    logic                sat_q;
    logic                push;
    logic                pop;
    logic                full;
    logic                wr_en;
    logic                drop;
    logic                sat_set;

    // Control delay line: valid/addr/first/last travel NUM_COLS stages beside lane 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_pipe <= '0;
            f_pipe <= '0;
            l_pipe <= '0;
            for (int unsigned i = 0; i < NUM_COLS; i++) a_pipe[i] <= '0;
        end else begin
            v_pipe    <= {v_pipe[NUM_COLS-2:0], bus.in_valid};
            f_pipe    <= {f_pipe[NUM_COLS-2:0], bus.acc_first};
            l_pipe    <= {l_pipe[NUM_COLS-2:0], bus.acc_last};
            a_pipe[0] <= bus.in_addr;
            for (int unsigned i = 1; i < NUM_COLS; i++) a_pipe[i] <= a_pipe[i-1];
        end
    end

    assign al_valid = v_pipe[NUM_COLS-1];
    assign al_first = f_pipe[NUM_COLS-1];
    assign al_last  = l_pipe[NUM_COLS-1];
    assign al_addr  = a_pipe[NUM_COLS-1];
    assign acc_old  = bank[al_addr];

    for (genvar c = 0; c < NUM_COLS; c++) begin : g_lane
        localparam int unsigned D = NUM_COLS - c;
        logic [31:0] dl [D];
        logic [31:0] p;
        logic [31:0] o;
        logic [32:0] s;
        logic        clip;

        // Lane c arrives c cycles late, so it needs NUM_COLS-c stages to line up
        always_ff @(posedge clk) begin
            dl[0] <= bus.in_sum[c*32 +: 32];
            for (int unsigned k = 1; k < D; k++) dl[k] <= dl[k-1];
        end

        assign p    = dl[D-1];
        assign o    = acc_old[c*32 +: 32];
        assign s    = {o[31], o} + {p[31], p};
        assign clip = s[32] ^ s[31];
        assign al_sum[c*32 +: 32]  = p;
        assign new_vec[c*32 +: 32] = al_first ? p :
                                     clip ? (s[32] ? 32'h8000_0000 : 32'h7FFF_FFFF) : s[31:0];
        assign lane_clip[c] = ~al_first & clip;
    end

    assign sat_set = al_valid & (|lane_clip);

    // Accumulator bank: flop array so next cycle's read sees this cycle's write
    always_ff @(posedge clk) begin
        if (al_valid) bank[al_addr] <= new_vec;
    end

    assign push  = al_valid & al_last;
    assign pop   = out_valid_q & bus.out_ready;
    assign full  = (count == CW'(FIFO_DEPTH));
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    // FIFO occupancy next-state
    always_comb begin
        count_nxt = count;
        if (wr_en && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !wr_en) begin
            count_nxt = count - CW'(1);
        end
    end

    // FIFO storage; a full FIFO that pops can overwrite the head slot it is releasing
    always_ff @(posedge clk) begin
        if (wr_en) fifo_mem[wr_ptr] <= new_vec;
    end

    // FIFO pointers, output valid and sticky error flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PW'(1);
            if (pop)   rd_ptr <= rd_ptr + PW'(1);
            count       <= count_nxt;
            out_valid_q <= (count_nxt != '0);
            ovf_q       <= drop    ? 1'b1 : (bus.err_clr ? 1'b0 : ovf_q);
            sat_q       <= sat_set ? 1'b1 : (bus.err_clr ? 1'b0 : sat_q);
        end
    end

    // Backpressure: queued entries plus acc_last vectors still travelling the deskew pipe
    always_comb begin
        pending = TW'(count);
        for (int unsigned i = 0; i < NUM_COLS; i++) begin
            pending = pending + TW'(v_pipe[i] & l_pipe[i]);
        end
    end

    assign bus.stall     = (pending >= TW'(FIFO_DEPTH - 1));
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = fifo_mem[rd_ptr];
    assign bus.err_ovf   = ovf_q;
    assign bus.err_sat   = sat_q;
endmodule
